// File: rtl/io_pattern_pkg.sv
// -----------------------------------------------------------------------------
// io_pattern_pkg
// Shared types for the open-drain IO pattern engine.
//   state_t : sequencer states (IDLE, DRIVE, SETTLE, CHECK, HOLD)
//   mode_t  : pattern selection (counter, walking-one, walking-zero,
//             per-channel offset counter)
//   ERR_W   : width of the saturating error counter
// -----------------------------------------------------------------------------
package io_pattern_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK1  = 2'd1,
        MODE_WALK0  = 2'd2,
        MODE_OFFSET = 2'd3
    } mode_t;

endpackage

// File: rtl/io_sync.sv
// -----------------------------------------------------------------------------
// io_sync
// Two-flop synchroniser for asynchronous pad levels.
// Ports:
//   clk   : sampling clock (rising edge)
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input bus
//   q     : synchronised output bus (two clk edges of latency)
// -----------------------------------------------------------------------------
module io_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: both stages are reset so the first CHECK after reset compares
    // against a known value rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_pattern_engine.sv
// -----------------------------------------------------------------------------
// io_pattern_engine
// Drives test patterns onto CHANNELS open-drain ports of WIDTH bits each and,
// optionally, reads the pads back after a settle time to detect stuck or
// shorted pins.
//
// Build option:
//   IO_LOOPBACK_CHECK_EN  defined   -> pin_in is synchronised and compared in
//                                      CHECK; err_count/err_mask are live.
//                         undefined -> pin_in unused, err_count/err_mask are 0;
//                                      sequencing is identical.
//
// Parameters:
//   WIDTH    : bits per port (power of two, 2..32)
//   CHANNELS : number of ports
//   SETTLE   : settle cycles between drive and readback (3..255)
//   DIV_W    : width of step_div
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   enable     : sequencer runs while high; low forces IDLE next edge
//   mode       : pattern select, latched on IDLE->DRIVE
//   step_div   : extra HOLD cycles per step (0 = no HOLD)
//   clear      : zeroes error state next edge (wins over an increment)
//   pin_in     : raw asynchronous pad levels
//   pin_pull   : registered pull-down enables, 1 = pull low
//   err_count  : saturating count of CHECK cycles with any mismatch
//   err_mask   : sticky per-channel mismatch flags
//   running    : high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module io_pattern_engine
    import io_pattern_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int SETTLE   = 4,
    parameter int DIV_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [DIV_W-1:0]          step_div,
    input  logic                      clear,
    input  logic [CHANNELS*WIDTH-1:0] pin_in,
    output logic [CHANNELS*WIDTH-1:0] pin_pull,
    output logic [ERR_W-1:0]          err_count,
    output logic [CHANNELS-1:0]       err_mask,
    output logic                      running
);

    localparam int TOTAL = CHANNELS * WIDTH;
    localparam int IDX_W = $clog2(WIDTH);
    // One counter serves both SETTLE (<=255) and HOLD (step_div) timing.
    localparam int CNT_W = (DIV_W > 8) ? DIV_W : 8;

    state_t             state;
    mode_t              mode_q;
    logic [WIDTH-1:0]   step;
    logic [CNT_W-1:0]   cnt;
    logic [TOTAL-1:0]   pattern;

    logic [CNT_W-1:0]   step_div_ext;
    logic [CNT_W:0]     cnt_inc;
    logic               settle_done;
    logic               hold_done;

    // -------------------------------------------------------------------------
    // Pattern generation for the current step under the latched mode.
    // -------------------------------------------------------------------------
    function automatic logic [TOTAL-1:0] build_pattern(
        input mode_t            m,
        input logic [WIDTH-1:0] s
    );
        logic [TOTAL-1:0] p;
        logic [WIDTH-1:0] onehot;
        p      = '0;
        onehot = WIDTH'(1) << s[IDX_W-1:0];
        for (int k = 0; k < CHANNELS; k++) begin
            case (m)
                MODE_COUNT:  p[k*WIDTH +: WIDTH] = s;
                MODE_WALK1:  p[k*WIDTH +: WIDTH] = onehot;
                MODE_WALK0:  p[k*WIDTH +: WIDTH] = ~onehot;
                MODE_OFFSET: p[k*WIDTH +: WIDTH] = s + WIDTH'(k);
                default:     p[k*WIDTH +: WIDTH] = s;
            endcase
        end
        return p;
    endfunction

    assign pattern = build_pattern(mode_q, step);

    // -------------------------------------------------------------------------
    // Phase timing. hold_done uses >= so a step_div lowered mid-HOLD still
    // terminates instead of running the counter round.
    // -------------------------------------------------------------------------
    assign step_div_ext = CNT_W'(step_div);
    assign cnt_inc      = {1'b0, cnt} + (CNT_W+1)'(1);
    assign settle_done  = (cnt == CNT_W'(SETTLE - 1));
    assign hold_done    = (cnt_inc >= {1'b0, step_div_ext});

    // -------------------------------------------------------------------------
    // Sequencer. pin_pull only changes on the DRIVE->SETTLE edge or when the
    // engine is stopped, so CHECK always sees the pattern loaded in DRIVE.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_COUNT;
            step     <= '0;
            cnt      <= '0;
            pin_pull <= '0;
            running  <= 1'b0;
        end else if (!enable) begin
            state    <= ST_IDLE;
            step     <= '0;
            cnt      <= '0;
            pin_pull <= '0;
            running  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mode_q  <= mode_t'(mode);
                    cnt     <= '0;
                    state   <= ST_DRIVE;
                    running <= 1'b1;
                end
                ST_DRIVE: begin
                    pin_pull <= pattern;
                    cnt      <= '0;
                    state    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    cnt <= '0;
                    if (step_div == '0) begin
                        step  <= step + WIDTH'(1);
                        state <= ST_DRIVE;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        cnt   <= '0;
                        step  <= step + WIDTH'(1);
                        state <= ST_DRIVE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef IO_LOOPBACK_CHECK_EN
    // -------------------------------------------------------------------------
    // Loopback comparison: a released pin (pull=0) must read high, a pulled
    // pin must read low, so the expected pad level is ~pin_pull.
    // -------------------------------------------------------------------------
    logic [TOTAL-1:0]    pin_sync;
    logic [CHANNELS-1:0] mismatch;

    io_sync #(
        .WIDTH (TOTAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin_in),
        .q     (pin_sync)
    );

    // NOTE: combinational outputs get a default before the loop so no path
    // leaves them unassigned and a latch can never be inferred.
    always_comb begin
        mismatch = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            mismatch[k] = (pin_sync[k*WIDTH +: WIDTH] != ~pin_pull[k*WIDTH +: WIDTH]);
        end
    end

    // Errors are only scored on a real CHECK cycle; an enable drop during
    // CHECK abandons the step and leaves the error state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            err_mask  <= '0;
        end else if (clear) begin
            err_count <= '0;
            err_mask  <= '0;
        end else if (enable && state == ST_CHECK && |mismatch) begin
            if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
            end
            err_mask <= err_mask | mismatch;
        end
    end
`else
    // Readback disabled: the pads are never observed and no errors exist.
    logic unused_pin_in;
    logic unused_clear;

    assign unused_pin_in = ^pin_in;
    assign unused_clear  = clear;
    assign err_count     = '0;
    assign err_mask      = '0;
`endif

endmodule

// File: doc/io_pattern_engine.md
IO_PATTERN_ENGINE -- requirements
Module: io_pattern_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per port; power of two, 2..32.
REQ-002 SHALL have parameter CHANNELS, default 3, number of open-drain ports.
REQ-003 SHALL have parameter SETTLE, default 4, settle cycles before readback; range 3..255.
REQ-004 SHALL have parameter DIV_W, default 16, width of step_div.
REQ-005 SHALL have port clk  in  1  single clock; all flops on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  in  1  run while high.
REQ-008 SHALL have port mode  in  2  pattern: 0 counter, 1 walking-one, 2 walking-zero, 3 channel-offset counter.
REQ-009 SHALL have port step_div  in  DIV_W  extra hold cycles per step.
REQ-010 SHALL have port clear  in  1  clears error state.
REQ-011 SHALL have port pin_in  in  CHANNELS*WIDTH  raw pad levels, asynchronous.
REQ-012 SHALL have port pin_pull  out  CHANNELS*WIDTH  registered; 1 = pull pad low, 0 = release.
REQ-013 SHALL have port err_count  out  16  mismatching checks, saturating.
REQ-014 SHALL have port err_mask  out  CHANNELS  sticky per-channel mismatch flags.
REQ-015 SHALL have port running  out  1  high when state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE, DRIVE, SETTLE, CHECK, HOLD.
REQ-017 IDLE->DRIVE when enable=1; mode latched on this transition only.
REQ-018 DRIVE lasts 1 cycle and loads pin_pull with the pattern for the current step.
REQ-019 SETTLE lasts exactly SETTLE cycles, then CHECK lasts 1 cycle, then HOLD.
REQ-020 HOLD lasts step_div cycles (0 = skip), then step increments and the FSM enters DRIVE; step period = SETTLE+2+step_div cycles.
REQ-021 step is a WIDTH-bit counter from 0 that wraps to 0 after 2^WIDTH-1.
REQ-022 Channel k pattern: mode 0 = step; mode 1 = 1<<(step mod WIDTH); mode 2 = ~(1<<(step mod WIDTH)); mode 3 = (step+k) mod 2^WIDTH.
REQ-023 In CHECK, channel k mismatches if synchronised pin_in slice != ~pin_pull slice.
REQ-024 Any mismatch in CHECK increments err_count by 1 (saturating at 16'hFFFF) and sets err_mask[k] for each mismatching k.
REQ-025 clear=1 zeroes err_count and err_mask on the next edge, taking priority over a simultaneous increment.
REQ-026 enable=0 in any state forces IDLE and pin_pull=0 on the next edge; step resets to 0; error state holds.
REQ-027 The FSM SHALL never leave IDLE or reach CHECK with pin_pull changed since DRIVE.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, pin_pull=0, step=0, err_count=0, err_mask=0, running=0, synchroniser flops=0.
REQ-029 Deassertion SHALL be honoured on the first clk edge with rst_n high; a running sequence restarts from step 0.

Configuration
REQ-030 Macro IO_LOOPBACK_CHECK_EN defined SHALL include synchroniser, comparison and error logic as above.
REQ-031 Without IO_LOOPBACK_CHECK_EN, pin_in SHALL be unused, CHECK SHALL pass straight to HOLD, and err_count/err_mask SHALL be constant 0; sequencing is unchanged.

Structure
REQ-032 Shared package io_pattern_pkg SHALL hold the state enum, the mode enum (MODE_COUNT, MODE_WALK1, MODE_WALK0, MODE_OFFSET) and ERR_W=16.
REQ-033 Sub-module io_sync (2-flop synchroniser, parametrised width, async active-low reset) SHALL register pin_in.

Verification
REQ-034 WIDTH=8, CHANNELS=3, SETTLE=4, step_div=0, mode 0, pin_in=~pin_pull loopback -> pin_pull steps every 6 cycles 00,01,02..., err_count stays 0.
REQ-035 Mode 1, 9 steps -> channel 0 pin_pull 01,02,04,...,80,01; mode 2 -> FE,FD,...
REQ-036 Mode 3 at step 5 -> slices 05,06,07; at step FF -> FF,00,01 (wrap).
REQ-037 Channel 1 bit 3 stuck low over 10 checks -> err_mask=3'b010, err_count=count of steps with bit 3 released.
REQ-038 clear and mismatch in the same CHECK cycle -> err_count=0 afterwards; enable dropped mid-SETTLE -> IDLE, pin_pull=0 next cycle.
REQ-039 rst_n pulsed low mid-HOLD -> all outputs 0 immediately, without waiting for clk.
